// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Holds the transmitter state encoding, the default bit period in clocks
// and the number of data bits per frame.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 87;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     write request and data (ignored when full)
//   pop, head           read request (ignored when empty) and head-of-queue data
//   full, empty, count  occupancy flags and current entry count
// A push is blocked whenever the FIFO is full, even if a pop happens on the
// same edge; the producer sees full as "not ready" and retries.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = DATA_BITS,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only readable once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, with a small input byte buffer.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   data_in, data_valid   byte offered by the producer
//   data_ready            buffer can accept a byte this cycle
//   tx_pin                registered serial line, idle high
//   tx_busy               a frame is on the line
//   tx_done               pulse on the last clock of each stop bit
//   fifo_count            bytes waiting, excluding the one being shifted
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (0) for CLKS_PER_BIT clocks
// DATA  | data bits shift[0]..shift[7], CLKS_PER_BIT clocks each
// STOP  | stop bit (1); chains straight into START if a byte is waiting
module uart_tx
    import uart_pkg::*;
#(
    parameter int  CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int  FIFO_DEPTH   = 4,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx_pin,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int                IDX_W     = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    tx_state_t            state, state_next;
    logic [BAUD_W-1:0]    baud, baud_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 tx_next;
    logic                 baud_end;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign data_ready = !fifo_full;
    assign baud_end   = (baud == BAUD_LAST);
    assign tx_busy    = (state != IDLE);
    assign tx_done    = (state == STOP) && baud_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_pin  <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx_pin  <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_idx == IDX_LAST) state_next = STOP;
                    else                     bit_idx_next = bit_idx + 1'b1;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // The line is registered from the next state so the start bit
        // appears on the cycle right after the pop.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[bit_idx_next];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int DEPTH = 4;
    localparam int CPB_A = 87;
    localparam int CPB_B = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    data_in = 8'h00;
    logic          data_valid = 1'b0;
    logic          ready_a, pin_a, busy_a, done_a;
    logic          ready_b, pin_b, busy_b, done_b;
    logic [CW-1:0] count_a, count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (ready_a),
        .tx_pin     (pin_a),
        .tx_busy    (busy_a),
        .tx_done    (done_a),
        .fifo_count (count_a)
    );

    uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (ready_b),
        .tx_pin     (pin_b),
        .tx_busy    (busy_b),
        .tx_done    (done_b),
        .fifo_count (count_b)
    );

    // Reference model: a byte queue plus the position inside the current
    // frame; the line level is looked up from the 10-bit frame by position.
    logic [7:0] mq [2][$];
    bit         m_act [2];
    int         m_pos [2];
    logic [7:0] m_cur [2];

    function automatic int cpb_of(input int i);
        return (i == 0) ? CPB_A : CPB_B;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            m_act[i] = 1'b0;
            m_pos[i] = 0;
        end
    endfunction

    function automatic void model_step(input int i);
        bit ready, end_f, pop, push;
        ready = mq[i].size() < DEPTH;
        end_f = m_act[i] && (m_pos[i] == 10 * cpb_of(i) - 1);
        pop   = (mq[i].size() > 0) && (!m_act[i] || end_f);
        push  = data_valid && ready;
        if (pop) begin
            m_cur[i] = mq[i].pop_front();
            m_act[i] = 1'b1;
            m_pos[i] = 0;
        end else if (end_f) begin
            m_act[i] = 1'b0;
        end else if (m_act[i]) begin
            m_pos[i]++;
        end
        if (push) mq[i].push_back(data_in);
    endfunction

    function automatic logic [63:0] model_out(input int i);
        logic          pin, done, rdy;
        int            k;
        logic [CW-1:0] cnt;
        pin = 1'b1;
        if (m_act[i]) begin
            k = m_pos[i] / cpb_of(i);
            if (k == 0)      pin = 1'b0;
            else if (k <= 8) pin = m_cur[i][k-1];
        end
        done = m_act[i] && (m_pos[i] == 10 * cpb_of(i) - 1);
        rdy  = mq[i].size() < DEPTH;
        cnt  = CW'(mq[i].size());
        return 64'({pin, m_act[i], done, rdy, cnt});
    endfunction

    function automatic logic [63:0] out_a();
        return 64'({pin_a, busy_a, done_a, ready_a, count_a});
    endfunction

    function automatic logic [63:0] out_b();
        return 64'({pin_b, busy_b, done_b, ready_b, count_b});
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        check("out_a", out_a(), model_out(0));
        check("out_b", out_b(), model_out(1));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy_a || busy_b || count_a != 0 || count_b != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", 64'(n < budget), 64'(1));
    endtask

    logic [63:0] idle_vec;
    logic [63:0] obs, exp;
    logic [9:0]  frame10;
    logic [7:0]  bytes [6];
    logic [7:0]  base;
    int          n, k, b, d1, d2, nd;
    bit          acc, saw_full, any_busy;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_vec = 64'({1'b1, 1'b0, 1'b0, 1'b1, CW'(0)});
        model_clear();

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_a", out_a(), idle_vec);
        check("reset_b", out_b(), idle_vec);
        reset = 1'b0;
        repeat (5) tick();

        // Single byte 0xA5 from idle: two-cycle latency, tx_done on cycle 870
        data_in = 8'hA5; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("a5_line_high_after_push", 64'(pin_a), 64'(1));
        tick();
        check("a5_start_2_cycles", 64'(pin_a), 64'(0));
        n = 1;
        while (!done_a && n < 2000) begin
            tick();
            n++;
        end
        check("a5_done_cycle", 64'(n), 64'(870));
        drain(2000);

        // Short bit period: exact 40-cycle waveform for 0x3C
        data_in = 8'h3C; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tick();
        frame10 = {1'b1, 8'h3C, 1'b0};
        obs = '0;
        exp = '0;
        for (int c = 0; c < 40; c++) begin
            obs[c] = pin_b;
            exp[c] = frame10[c / CPB_B];
            if (c < 39) tick();
        end
        check("cpb4_waveform", obs, exp);
        drain(2000);

        // 0x00 then 0xFF back to back: 1740 contiguous busy cycles
        data_in = 8'h00; data_valid = 1'b1;
        tick();
        data_in = 8'hFF;
        tick();
        data_valid = 1'b0;
        n = 0;
        while (!busy_a && n < 10) begin
            tick();
            n++;
        end
        b = 0; nd = 0; d1 = 0; d2 = 0;
        while (busy_a && b < 5000) begin
            b++;
            if (done_a) begin
                nd++;
                if (nd == 1) d1 = b;
                else         d2 = b;
            end
            tick();
        end
        check("b2b_busy_len", 64'(b), 64'(1740));
        check("b2b_done_count", 64'(nd), 64'(2));
        check("b2b_done_gap", 64'(d2 - d1), 64'(870));
        drain(2000);

        // Hold data_valid with 6 distinct bytes; full buffer drops a push on pop
        base = 8'($urandom);
        for (int i = 0; i < 6; i++) bytes[i] = base + 8'(i * 41);
        k = 0; n = 0; saw_full = 1'b0;
        while (k < 6 && n < 10000) begin
            data_in = bytes[k];
            data_valid = 1'b1;
            acc = ready_a;
            if (k == 5 && !acc && !saw_full) begin
                check("hold_full_count", 64'(count_a), 64'(4));
                check("hold_full_ready", 64'(ready_a), 64'(0));
                saw_full = 1'b1;
            end
            if (k == 5 && acc && saw_full)
                check("full_pop_drop_count", 64'(count_a), 64'(DEPTH - 1));
            tick();
            if (acc) k++;
            n++;
        end
        data_valid = 1'b0;
        check("hold_all_accepted", 64'(k), 64'(6));
        check("hold_saw_full", 64'(saw_full), 64'(1));
        drain(8000);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            data_valid = ($urandom_range(0, 99) < 20);
            data_in = 8'($urandom);
            tick();
        end
        data_valid = 1'b0;
        drain(6000);

        // Reset mid-frame (data bit 3) with two bytes buffered
        for (int i = 0; i < 3; i++) begin
            data_in = 8'($urandom);
            data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        n = 0;
        while (!(m_act[0] && m_pos[0] == 4 * CPB_A + 10) && n < 3000) begin
            tick();
            n++;
        end
        check("pre_reset_count", 64'(count_a), 64'(2));
        check("pre_reset_busy", 64'(busy_a), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_a", out_a(), idle_vec);
        model_clear();
        repeat (2) tick();
        reset = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            any_busy = any_busy | busy_a | busy_b;
        end
        check("no_frame_after_reset", 64'(any_busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clocks per serial bit; legal range 4..127.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit byte buffer entries; power of two, 2..16.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 data_in  input  8  byte to transmit, sampled when data_valid and data_ready are both high.
REQ-006 data_valid  input  1  producer offers data_in this cycle.
REQ-007 data_ready  output  1  buffer can accept a byte this cycle.
REQ-008 tx_pin  output  1  serial line, idle high, registered.
REQ-009 tx_busy  output  1  high while a frame is on the line (START, DATA, STOP).
REQ-010 tx_done  output  1  one-cycle pulse on the last clock of each stop bit.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered, excluding the byte being shifted.

Function
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; each bit held exactly CLKS_PER_BIT cycles.
REQ-013 Push SHALL occur on a rising edge with data_valid=1 and data_ready=1; data_ready = (fifo_count < FIFO_DEPTH).
REQ-014 When the FIFO is full, a push SHALL NOT occur, even if a pop happens in the same cycle; data_valid with data_ready=0 SHALL have no effect.
REQ-015 A push and a pop in the same cycle SHALL leave fifo_count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 States: IDLE, START, DATA, STOP; baud counter 0..CLKS_PER_BIT-1; bit index 0..7.
REQ-017 IDLE: tx_pin=1; if FIFO non-empty, pop head into shift register, clear baud counter, go to START.
REQ-018 START: tx_pin=0; at baud counter = CLKS_PER_BIT-1, clear counter, bit index=0, go to DATA.
REQ-019 DATA: tx_pin=shift[bit index]; at counter end, if bit index=7 go to STOP, else increment bit index.
REQ-020 STOP: tx_pin=1; at counter end, pulse tx_done; if FIFO non-empty, pop and go straight to START (no idle gap); else go to IDLE.
REQ-021 tx_pin SHALL first go low on the cycle after the pop; push-to-line latency from an idle, empty block SHALL be 2 cycles.
REQ-022 A byte pushed into an empty FIFO on the same edge the IDLE state samples it as empty SHALL be popped on the following cycle.
REQ-023 tx_busy SHALL be 1 in START, DATA and STOP and 0 in IDLE; the shift register SHALL NOT change mid-frame.
REQ-024 One frame SHALL occupy exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be contiguous.

Reset
REQ-025 Reset SHALL force state IDLE, tx_pin=1, tx_busy=0, tx_done=0, data_ready=1, fifo_count=0, all counters/pointers 0, at any time, including mid-frame; buffered bytes are discarded.
REQ-026 After reset deasserts, no frame SHALL start until a new push occurs.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state typedef (IDLE, START, DATA, STOP), default CLKS_PER_BIT=87, DATA_BITS=8.
REQ-028 The buffer SHALL be a sub-module uart_tx_fifo (synchronous FIFO, push/pop/full/empty/count), instantiated once.

Verification
REQ-029 Push 0xA5 when idle -> tx_pin low 2 cycles later for 87 cycles, then 1,0,1,0,0,1,0,1 at 87 cycles each, then high 87 cycles; tx_done pulses at cycle 870 from start-bit edge.
REQ-030 Push 0x00 then 0xFF on consecutive cycles -> 1740 contiguous cycles, stop bit of frame 1 directly followed by start bit of frame 2; two tx_done pulses 870 cycles apart.
REQ-031 Hold data_valid high with 6 distinct bytes while idle -> first popped, 4 buffered, data_ready=0 with fifo_count=4; the sixth is accepted only once fifo_count drops to 3; all 6 bytes transmitted in order.
REQ-032 Assert reset in DATA state at bit 3 with 2 bytes buffered -> tx_pin=1 immediately, fifo_count=0, tx_busy=0; no further frames after release.
REQ-033 With CLKS_PER_BIT=4, push 0x3C -> exact 40-cycle waveform matching REQ-012 bit order.
REQ-034 Push with FIFO full and a pop in the same cycle -> byte dropped, fifo_count=FIFO_DEPTH-1 afterwards.
